// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_tx_state_t : transmitter FSM encoding
//   DEF_CLK_FREQ    : default system clock frequency (Hz)
//   DEF_BAUD        : default line rate (bit/s)
//   UART_DATA_AD    : IOBUS address whose write pushes a byte
//   UART_RDY_AD     : IOBUS address whose read returns READY
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START_B, DATA_B, STOP_B} uart_tx_state_t;

   localparam int DEF_CLK_FREQ = 100_000_000;
   localparam int DEF_BAUD     = 115_200;

   localparam logic [31:0] UART_DATA_AD = 32'h1118_0000;
   localparam logic [31:0] UART_RDY_AD  = 32'h111C_0000;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side handshake bundle of the UART transmitter.
//   start    : 1-cycle write strobe, push data
//   data     : byte to queue
//   ready    : FIFO not full
//   busy     : frame on the line or bytes queued
//   overflow : sticky, a write was dropped while full
//   count    : bytes queued (excluding the byte in flight)
//   tx       : serial line, idle high
// master = bus decode side, slave = transmitter.
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          start;
   logic [7:0]    data;
   logic          ready;
   logic          busy;
   logic          overflow;
   logic [CW-1:0] count;
   logic          tx;

   modport master (
      output start, data,
      input  ready, busy, overflow, count, tx
   );

   modport slave (
      input  start, data,
      output ready, busy, overflow, count, tx
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and a fall-through
// read port (dout always shows the oldest entry).
//   sclk, rst    : clock, asynchronous active-high reset
//   push, din    : write request and data; ignored when full
//   pop          : read request; ignored when empty
//   dout         : head entry
//   full, empty  : registered status
//   count        : number of stored entries
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     sclk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic             push_ok;
   logic             pop_ok;

   // full is the registered flag, so a push on a full edge is dropped even
   // when a pop frees a slot on that same edge
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + 1'b1;
      else if (pop_ok && !push_ok)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge sclk) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queued 8N1 UART transmitter, LSB first.
//   sclk : system clock
//   rst  : asynchronous active-high reset; aborts any frame in flight
//   bus  : slave side of uart_tx_fifo_if (start/data in; ready, busy,
//          overflow, count, tx out)
//
// state   | meaning
// IDLE    | line high, waiting for a queued byte
// START_B | start bit (low) for one bit time
// DATA_B  | data bits 0..7, one bit time each
// STOP_B  | stop bit (high); pops the next byte at its end if one is queued
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int BAUD       = DEF_BAUD,
   parameter int FIFO_DEPTH = 8
) (
   input  logic           sclk,
   input  logic           rst,
   uart_tx_fifo_if.slave  bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int TW           = $clog2(CLKS_PER_BIT);
   localparam int CW           = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);

   uart_tx_state_t state, state_nxt;
   logic [TW-1:0]  timer, timer_nxt;
   logic [2:0]     idx, idx_nxt;
   logic [7:0]     sh, sh_nxt;
   logic           tx_q, tx_nxt;
   logic           ovf_q, ovf_nxt;
   logic           pop;
   logic           bit_done;

   logic [7:0]     fifo_dout;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  fifo_count;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sclk  (sclk),
      .rst   (rst),
      .push  (bus.start),
      .din   (bus.data),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // bit timer counts down from CLKS_PER_BIT-1; zero ends the current bit
   assign bit_done = (timer == '0);

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      idx_nxt   = idx;
      sh_nxt    = sh;
      tx_nxt    = tx_q;
      pop       = 1'b0;
      ovf_nxt   = ovf_q | (bus.start & fifo_full);

      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               sh_nxt    = fifo_dout;
               timer_nxt = BIT_LOAD;
               tx_nxt    = 1'b0;
               state_nxt = START_B;
            end
         end
         START_B: begin
            if (bit_done) begin
               timer_nxt = BIT_LOAD;
               idx_nxt   = 3'd0;
               tx_nxt    = sh[0];
               state_nxt = DATA_B;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         DATA_B: begin
            if (bit_done) begin
               timer_nxt = BIT_LOAD;
               if (idx == 3'd7) begin
                  tx_nxt    = 1'b1;
                  state_nxt = STOP_B;
               end else begin
                  sh_nxt  = {1'b0, sh[7:1]};
                  tx_nxt  = sh[1];
                  idx_nxt = idx + 3'd1;
               end
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         STOP_B: begin
            if (bit_done) begin
               // next byte goes straight into its start bit, no idle gap
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  sh_nxt    = fifo_dout;
                  timer_nxt = BIT_LOAD;
                  tx_nxt    = 1'b0;
                  state_nxt = START_B;
               end else begin
                  tx_nxt    = 1'b1;
                  state_nxt = IDLE;
               end
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         default: begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         idx   <= '0;
         sh    <= '0;
         tx_q  <= 1'b1;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         idx   <= idx_nxt;
         sh    <= sh_nxt;
         tx_q  <= tx_nxt;
         ovf_q <= ovf_nxt;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.ready    = ~fifo_full;
   assign bus.busy     = (state != IDLE) | ~fifo_empty;
   assign bus.overflow = ovf_q;
   assign bus.count    = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with 16 clocks per bit and a 4-deep FIFO.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

   logic sclk = 1'b0;
   logic rst  = 1'b1;
   int   checks = 0;
   int   errors = 0;

   uart_tx_fifo_if #(.FIFO_DEPTH(4)) bus ();

   uart_tx_fifo #(
      .CLK_FREQ   (16),
      .BAUD       (1),
      .FIFO_DEPTH (4)
   ) dut (
      .sclk (sclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 sclk = ~sclk;

   // Checks one 160-cycle frame of byte b, starting at sample index skip.
   // Sample 0 is the first falling edge after the start bit goes out.
   task automatic check_frame(input logic [7:0] b, input int skip, input string name);
      logic exp;
      int   k;
      for (int i = skip; i < 160; i++) begin
         @(negedge sclk);
         k = i / 16;
         if (k == 0)
            exp = 1'b0;
         else if (k == 9)
            exp = 1'b1;
         else
            exp = b[k-1];
         checks++;
         if (bus.tx !== exp) begin
            errors++;
            $display("FAIL %s tx sample %0d: got %b expected %b", name, i, bus.tx, exp);
         end
      end
   endtask

   task automatic push(input logic [7:0] d);
      bus.start = 1'b1;
      bus.data  = d;
      @(negedge sclk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.data  = 8'h00;
      rst       = 1'b1;
      repeat (3) @(negedge sclk);
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_held tx/busy: got %b/%b expected 1/0", bus.tx, bus.busy);
      end
      rst = 1'b0;
      repeat (50) @(negedge sclk);
      checks++;
      if (bus.tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx: got %b expected 1", bus.tx);
      end
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1", bus.ready);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", bus.busy);
      end
      checks++;
      if (bus.count !== 3'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", bus.count);
      end
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_overflow: got %b expected 0", bus.overflow);
      end
   endtask

   task automatic test_single();
      push(8'hA5);
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b1 || bus.count !== 3'd1) begin
         errors++;
         $display("FAIL single_after_push tx/busy/count: got %b/%b/%0d expected 1/1/1",
                  bus.tx, bus.busy, bus.count);
      end
      check_frame(8'hA5, 0, "single_a5");
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_last_stop: got %b expected 1", bus.busy);
      end
      @(negedge sclk);
      checks++;
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_fall busy/tx: got %b/%b expected 0/1", bus.busy, bus.tx);
      end
   endtask

   // Leaves the bench at sample index 3 of the 0x01 frame.
   task automatic test_burst();
      bus.start = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         bus.data = 8'(i);
         @(negedge sclk);
      end
      bus.start = 1'b0;
      checks++;
      if (bus.count !== 3'd4) begin
         errors++;
         $display("FAIL burst_count: got %0d expected 4", bus.count);
      end
      checks++;
      if (bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL burst_ready: got %b expected 0", bus.ready);
      end
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL burst_overflow: got %b expected 0", bus.overflow);
      end
      checks++;
      if (bus.tx !== 1'b0) begin
         errors++;
         $display("FAIL burst_start_bit: got %b expected 0", bus.tx);
      end
   endtask

   task automatic test_overflow();
      push(8'hFF);
      checks++;
      if (bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set: got %b expected 1", bus.overflow);
      end
      checks++;
      if (bus.count !== 3'd4) begin
         errors++;
         $display("FAIL overflow_count: got %0d expected 4", bus.count);
      end
      check_frame(8'h01, 5, "frame_01");
      check_frame(8'h02, 0, "frame_02");
      check_frame(8'h03, 0, "frame_03");
      check_frame(8'h04, 0, "frame_04");
      check_frame(8'h05, 0, "frame_05");
      @(negedge sclk);
      checks++;
      if (bus.busy !== 1'b0 || bus.count !== 3'd0) begin
         errors++;
         $display("FAIL burst_drain busy/count: got %b/%0d expected 0/0", bus.busy, bus.count);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge sclk);
         checks++;
         if (bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL dropped_byte_idle tx cycle %0d: got %b expected 1", i, bus.tx);
         end
      end
   endtask

   task automatic test_same_edge();
      bus.start = 1'b1;
      bus.data  = 8'h11; @(negedge sclk);
      bus.data  = 8'h22; @(negedge sclk);
      bus.data  = 8'h33; @(negedge sclk);
      bus.data  = 8'h44; @(negedge sclk);
      bus.start = 1'b0;
      checks++;
      if (bus.count !== 3'd3 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_setup count/ready: got %0d/%b expected 3/1", bus.count, bus.ready);
      end
      check_frame(8'h11, 3, "frame_11");
      // this write lands on the STOP->START pop edge
      push(8'h55);
      checks++;
      if (bus.count !== 3'd3) begin
         errors++;
         $display("FAIL same_edge_count: got %0d expected 3", bus.count);
      end
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_ready: got %b expected 1", bus.ready);
      end
      checks++;
      if (bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: got %b expected 1", bus.overflow);
      end
      check_frame(8'h22, 1, "frame_22");
      check_frame(8'h33, 0, "frame_33");
      check_frame(8'h44, 0, "frame_44");
      check_frame(8'h55, 0, "frame_55");
      @(negedge sclk);
      checks++;
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_drain busy/tx: got %b/%b expected 0/1", bus.busy, bus.tx);
      end
   endtask

   task automatic test_reset_mid_frame();
      bus.start = 1'b1;
      bus.data  = 8'h00; @(negedge sclk);
      bus.data  = 8'h66; @(negedge sclk);
      bus.data  = 8'h77; @(negedge sclk);
      bus.start = 1'b0;
      checks++;
      if (bus.count !== 3'd2) begin
         errors++;
         $display("FAIL abort_setup_count: got %0d expected 2", bus.count);
      end
      repeat (38) @(negedge sclk);
      checks++;
      if (bus.tx !== 1'b0) begin
         errors++;
         $display("FAIL abort_pre_tx: got %b expected 0", bus.tx);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.tx !== 1'b1) begin
         errors++;
         $display("FAIL abort_tx: got %b expected 1", bus.tx);
      end
      checks++;
      if (bus.count !== 3'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_count_busy: got %0d/%b expected 0/0", bus.count, bus.busy);
      end
      checks++;
      if (bus.overflow !== 1'b0 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ovf_ready: got %b/%b expected 0/1", bus.overflow, bus.ready);
      end
      @(negedge sclk);
      rst = 1'b0;
      @(negedge sclk);
      push(8'h3C);
      checks++;
      if (bus.count !== 3'd1) begin
         errors++;
         $display("FAIL post_reset_count: got %0d expected 1", bus.count);
      end
      check_frame(8'h3C, 0, "frame_3c");
      @(negedge sclk);
      checks++;
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_drain busy/tx: got %b/%b expected 0/1", bus.busy, bus.tx);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_same_edge();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
